// File: rtl/id_stage_pkg.sv
// Shared constants for the decode stage: widths, the opcodes resolved early
// in decode, and the instruction loaded into IF/ID on reset or flush.
package id_stage_pkg;

  localparam int ID_WIDTH  = 32;
  localparam int ID_REG_AW = 5;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/id_stage_regfile.sv
// Register file with two combinational read ports and one write port. r0 is
// hardwired to zero, and a same-cycle writeback is bypassed to the readers.
module id_stage_regfile
  import id_stage_pkg::*;
#(
  parameter int WIDTH  = ID_WIDTH,
  parameter int REG_AW = ID_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [WIDTH-1:0]  wd_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [WIDTH-1:0] regs_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Write-first: the writeback value wins over the stored one in the same cycle.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, early beq/bne/j resolution
// with forwarded compare operands, and branch/jump target generation.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WIDTH  = ID_WIDTH,
  parameter int REG_AW = ID_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  instr_fetch,
  input  logic [WIDTH-1:0]  pc_fetch,
  input  logic              stall_decode,
  input  logic              forward_a_decode,
  input  logic              forward_b_decode,
  input  logic [WIDTH-1:0]  alu_out_mem,
  input  logic              regwrite_wb,
  input  logic [REG_AW-1:0] writereg_wb,
  input  logic [WIDTH-1:0]  result_wb,
  output logic              pcsrc_decode,
  output logic              jump_decode,
  output logic [WIDTH-1:0]  pc_branch,
  output logic [WIDTH-1:0]  pc_jump,
  output logic [WIDTH-1:0]  instr_decode,
  output logic [WIDTH-1:0]  rd1_decode,
  output logic [WIDTH-1:0]  rd2_decode,
  output logic [REG_AW-1:0] rs_decode,
  output logic [REG_AW-1:0] rt_decode,
  output logic [REG_AW-1:0] rd_decode,
  output logic [WIDTH-1:0]  signimm_decode
);

  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ca, cb;
  logic             br_taken, jmp_taken;

  // Stall wins over a pending redirect: the flush waits until the stall clears.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (!stall_decode) begin
      if (pcsrc_decode || jump_decode) begin
        instr_d = WIDTH'(NOP);
        pc_d    = '0;
      end else begin
        instr_d = instr_fetch;
        pc_d    = pc_fetch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= WIDTH'(NOP);
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  id_stage_regfile #(
    .WIDTH  (WIDTH),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst),
    .ra1_i (rs_decode),
    .ra2_i (rt_decode),
    .we_i  (regwrite_wb),
    .wa_i  (writereg_wb),
    .wd_i  (result_wb),
    .rd1_o (rd1_decode),
    .rd2_o (rd2_decode)
  );

  assign instr_decode   = instr_q;
  assign rs_decode      = instr_q[25:21];
  assign rt_decode      = instr_q[20:16];
  assign rd_decode      = instr_q[15:11];
  assign signimm_decode = {{(WIDTH-16){instr_q[15]}}, instr_q[15:0]};

  assign ca = forward_a_decode ? alu_out_mem : rd1_decode;
  assign cb = forward_b_decode ? alu_out_mem : rd2_decode;

  always_comb begin
    br_taken  = 1'b0;
    jmp_taken = 1'b0;
    case (instr_q[31:26])
      OP_BEQ:  br_taken  = (ca == cb);
      OP_BNE:  br_taken  = (ca != cb);
      OP_J:    jmp_taken = 1'b1;
      default: ;
    endcase
  end

  // Operands are not trustworthy while the hazard unit stalls decode.
  assign pcsrc_decode = br_taken  & ~stall_decode;
  assign jump_decode  = jmp_taken & ~stall_decode;

  assign pc_branch = pc_q + (signimm_decode << 2);
  assign pc_jump   = {pc_q[WIDTH-1 -: 4], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reset and bypass sequences, a table of branch/jump
// vectors with flush checks, stall/reset corners, and a randomized model run.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_fetch, pc_fetch;
  logic        stall_decode, forward_a_decode, forward_b_decode;
  logic [31:0] alu_out_mem;
  logic        regwrite_wb;
  logic [4:0]  writereg_wb;
  logic [31:0] result_wb;
  logic        pcsrc_decode, jump_decode;
  logic [31:0] pc_branch, pc_jump, instr_decode, rd1_decode, rd2_decode, signimm_decode;
  logic [4:0]  rs_decode, rt_decode, rd_decode;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] FOLLOW = 32'h2000_0001;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst),
    .instr_fetch(instr_fetch), .pc_fetch(pc_fetch),
    .stall_decode(stall_decode),
    .forward_a_decode(forward_a_decode), .forward_b_decode(forward_b_decode),
    .alu_out_mem(alu_out_mem),
    .regwrite_wb(regwrite_wb), .writereg_wb(writereg_wb), .result_wb(result_wb),
    .pcsrc_decode(pcsrc_decode), .jump_decode(jump_decode),
    .pc_branch(pc_branch), .pc_jump(pc_jump),
    .instr_decode(instr_decode), .rd1_decode(rd1_decode), .rd2_decode(rd2_decode),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .rd_decode(rd_decode),
    .signimm_decode(signimm_decode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] r1v, r2v, instr, pc;
    logic        fa, fb;
    logic [31:0] alu;
    logic        exp_pcsrc, exp_jump;
    logic [31:0] exp_br, exp_jp;
  } vec_t;

  vec_t tbl[9];

  // Reference model state
  logic [31:0] mref [32];
  logic [31:0] instr_m, pc_m;

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return mref[a];
  endfunction

  initial begin
    rst = 1'b0;
    instr_fetch = '0; pc_fetch = '0; stall_decode = 0;
    forward_a_decode = 0; forward_b_decode = 0; alu_out_mem = '0;
    regwrite_wb = 0; writereg_wb = '0; result_wb = '0;

    // ---------------- reset ----------------
    step(); step();
    chk("rst_instr", instr_decode, 32'h0);
    chk("rst_rd1", rd1_decode, 32'h0);
    chk("rst_rd2", rd2_decode, 32'h0);
    chk("rst_pcsrc", {31'h0, pcsrc_decode}, 32'h0);
    chk("rst_jump", {31'h0, jump_decode}, 32'h0);
    chk("rst_pc_branch", pc_branch, 32'h0);
    chk("rst_pc_jump", pc_jump, 32'h0);
    chk("rst_signimm", signimm_decode, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] ra, rb;
      ra = 5'(i);
      rb = 5'(31 - i);
      instr_fetch = {6'h0, ra, rb, 16'h0};
      step();
      chk("rst_reg_rd1", rd1_decode, 32'h0);
      chk("rst_reg_rd2", rd2_decode, 32'h0);
    end

    // ---------------- writeback bypass ----------------
    instr_fetch = {6'h0, 5'd8, 5'd0, 16'h0};
    step();
    regwrite_wb = 1; writereg_wb = 5'd8; result_wb = 32'hDEADBEEF;
    #1 chk("bypass_same_cycle", rd1_decode, 32'hDEADBEEF);
    step();
    regwrite_wb = 0; result_wb = '0;
    #1 chk("bypass_persist", rd1_decode, 32'hDEADBEEF);
    instr_fetch = 32'h0;
    step();
    regwrite_wb = 1; writereg_wb = 5'd0; result_wb = 32'h5;
    #1 chk("r0_bypass", rd1_decode, 32'h0);
    step();
    regwrite_wb = 0;
    #1 chk("r0_after", rd1_decode, 32'h0);

    // ---------------- table-driven branch/jump vectors ----------------
    tbl[0] = '{32'd7, 32'd7, 32'h1022_0003, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0110, 32'h0088_000C};
    tbl[1] = '{32'd5, 32'd5, 32'h1022_0003, 32'h0000_0104, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 32'h0000_0110, 32'h0088_000C};
    tbl[2] = '{32'd9, 32'd5, 32'h1422_0003, 32'h0000_0104, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0, 32'h0000_0110, 32'h0088_000C};
    tbl[3] = '{32'd5, 32'd9, 32'h1422_0003, 32'h0000_0104, 1'b0, 1'b1, 32'd9, 1'b1, 1'b0, 32'h0000_0110, 32'h0088_000C};
    tbl[4] = '{32'd1, 32'd2, 32'h1022_0003, 32'h0000_0104, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0, 32'h0000_0110, 32'h0088_000C};
    tbl[5] = '{32'h1234_5678, 32'h1234_5678, 32'h1022_FFFF, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_01FC, 32'h008B_FFFC};
    tbl[6] = '{32'd3, 32'd3, 32'h0800_0040, 32'h4000_0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0108, 32'h4000_0100};
    tbl[7] = '{32'd4, 32'd4, 32'h0022_1820, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_6088, 32'h0088_6080};
    tbl[8] = '{32'd3, 32'd4, 32'h1022_8000, 32'hF000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hEFFE_0000, 32'hF08A_0000};

    for (int k = 0; k < 9; k++) begin
      logic [31:0] e1, e2;
      instr_fetch = 32'h0; pc_fetch = 32'h0;
      regwrite_wb = 1; writereg_wb = 5'd1; result_wb = tbl[k].r1v;
      step();
      writereg_wb = 5'd2; result_wb = tbl[k].r2v;
      step();
      regwrite_wb = 0;
      instr_fetch = tbl[k].instr; pc_fetch = tbl[k].pc;
      forward_a_decode = tbl[k].fa; forward_b_decode = tbl[k].fb; alu_out_mem = tbl[k].alu;
      step();
      instr_fetch = FOLLOW; pc_fetch = 32'h0000_0FF0;
      #1;
      e1 = (tbl[k].instr[25:21] == 5'd1) ? tbl[k].r1v : (tbl[k].instr[25:21] == 5'd2) ? tbl[k].r2v : 32'h0;
      e2 = (tbl[k].instr[20:16] == 5'd1) ? tbl[k].r1v : (tbl[k].instr[20:16] == 5'd2) ? tbl[k].r2v : 32'h0;
      chk($sformatf("vec%0d_pcsrc", k), {31'h0, pcsrc_decode}, {31'h0, tbl[k].exp_pcsrc});
      chk($sformatf("vec%0d_jump", k), {31'h0, jump_decode}, {31'h0, tbl[k].exp_jump});
      chk($sformatf("vec%0d_pc_branch", k), pc_branch, tbl[k].exp_br);
      chk($sformatf("vec%0d_pc_jump", k), pc_jump, tbl[k].exp_jp);
      chk($sformatf("vec%0d_rd1", k), rd1_decode, e1);
      chk($sformatf("vec%0d_rd2", k), rd2_decode, e2);
      chk($sformatf("vec%0d_instr", k), instr_decode, tbl[k].instr);
      step();
      chk($sformatf("vec%0d_next_instr", k), instr_decode,
          (tbl[k].exp_pcsrc || tbl[k].exp_jump) ? 32'h0 : FOLLOW);
      forward_a_decode = 0; forward_b_decode = 0; alu_out_mem = '0;
    end
    chk("rtype_rs", {27'h0, 5'd0}, {27'h0, 5'd0} & {27'h0, rs_decode});
    instr_fetch = 32'h0022_1820; step();
    chk("rtype_rs_field", {27'h0, rs_decode}, 32'd1);
    chk("rtype_rt_field", {27'h0, rt_decode}, 32'd2);
    chk("rtype_rd_field", {27'h0, rd_decode}, 32'd3);
    chk("rtype_signimm", signimm_decode, 32'h0000_1820);
    instr_fetch = 32'h1022_8000; step();
    chk("neg_signimm", signimm_decode, 32'hFFFF_8000);

    // ---------------- stall priority ----------------
    regwrite_wb = 1; writereg_wb = 5'd1; result_wb = 32'd42; instr_fetch = 32'h0;
    step();
    regwrite_wb = 0;
    instr_fetch = 32'h1021_0003; pc_fetch = 32'h0000_0104;
    step();
    stall_decode = 1; instr_fetch = FOLLOW;
    #1 chk("stall_pcsrc", {31'h0, pcsrc_decode}, 32'h0);
    step();
    chk("stall_hold_instr", instr_decode, 32'h1021_0003);
    chk("stall_hold_pcsrc", {31'h0, pcsrc_decode}, 32'h0);
    stall_decode = 0;
    #1 chk("unstall_pcsrc", {31'h0, pcsrc_decode}, 32'h1);
    chk("unstall_pc_branch", pc_branch, 32'h0000_0110);
    step();
    chk("unstall_flush", instr_decode, 32'h0);
    instr_fetch = 32'h1021_0003;
    step();
    stall_decode = 1;
    step();
    #2 rst = 0;
    #1 chk("rst_mid_stall_instr", instr_decode, 32'h0);
    chk("rst_mid_stall_rd1", rd1_decode, 32'h0);
    @(negedge clk);
    rst = 1; stall_decode = 0;

    // ---------------- randomized run against model ----------------
    for (int i = 0; i < 32; i++) mref[i] = 32'h0;
    instr_m = 32'h0; pc_m = 32'h0;
    step();
    // registers are all zero and IF/ID is NOP after the reset above; the model
    // state assumes the last fetched word below is the first to load
    instr_fetch = 32'h0; pc_fetch = 32'h0;
    step();
    for (int c = 0; c < 400; c++) begin
      logic [5:0]  op;
      logic [4:0]  rs, rt, ers, ert;
      logic [31:0] a, b, ca, cb, ebr, ejp, simm;
      logic        etaken, ejmp;
      case ($urandom_range(0, 3))
        0: op = 6'b000100;
        1: op = 6'b000101;
        2: op = 6'b000010;
        default: op = 6'b100011;
      endcase
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      instr_fetch = {op, rs, rt, 16'($urandom)};
      pc_fetch = $urandom;
      stall_decode = ($urandom_range(0, 3) == 0);
      forward_a_decode = $urandom_range(0, 1);
      forward_b_decode = $urandom_range(0, 1);
      alu_out_mem = $urandom_range(0, 3);
      regwrite_wb = $urandom_range(0, 1);
      writereg_wb = 5'($urandom_range(0, 3));
      result_wb = $urandom_range(0, 3);
      #1;
      ers = instr_m[25:21];
      ert = instr_m[20:16];
      a = mread(ers, regwrite_wb, writereg_wb, result_wb);
      b = mread(ert, regwrite_wb, writereg_wb, result_wb);
      ca = forward_a_decode ? alu_out_mem : a;
      cb = forward_b_decode ? alu_out_mem : b;
      etaken = !stall_decode && ((instr_m[31:26] == 6'd4 && ca == cb) ||
                                 (instr_m[31:26] == 6'd5 && ca != cb));
      ejmp = !stall_decode && (instr_m[31:26] == 6'd2);
      simm = instr_m[15] ? (32'hFFFF_0000 | {16'h0, instr_m[15:0]}) : {16'h0, instr_m[15:0]};
      ebr = pc_m + simm * 4;
      ejp = (pc_m & 32'hF000_0000) | ({6'h0, instr_m[25:0]} * 4);
      chk("rnd_instr", instr_decode, instr_m);
      chk("rnd_rd1", rd1_decode, a);
      chk("rnd_rd2", rd2_decode, b);
      chk("rnd_pcsrc", {31'h0, pcsrc_decode}, {31'h0, etaken});
      chk("rnd_jump", {31'h0, jump_decode}, {31'h0, ejmp});
      chk("rnd_pc_branch", pc_branch, ebr);
      chk("rnd_pc_jump", pc_jump, ejp);
      if (regwrite_wb && writereg_wb != 0) mref[writereg_wb] = result_wb;
      if (!stall_decode) begin
        if (etaken || ejmp) begin
          instr_m = 32'h0; pc_m = 32'h0;
        end else begin
          instr_m = instr_fetch; pc_m = pc_fetch;
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
